// File: rtl/bcd_to_bin_conv_pkg.sv
// Shared definitions for the BCD-to-binary converter.
// Holds the FSM state encoding and the digit-level constants used by the
// reverse double-dabble correction cell and the input range check.
package bcd_to_bin_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] MAX_DIGIT   = 4'd9;  // largest legal BCD digit
  localparam logic [3:0] CORR_THRESH = 4'd8;  // post-shift digit needing correction
  localparam logic [3:0] CORR_SUB    = 4'd3;  // amount removed from such a digit

endpackage

// File: rtl/bcd_to_bin_conv_corr.sv
// bcd_digit_corr: combinational correction cell for reverse double-dabble.
// After a right shift, a BCD digit of 8 or more has received a bit worth
// "10/2 = 5" from the digit above, but binary weighting gave it 8; removing 3
// restores a valid BCD digit.
// Ports:
//   digit     - 4-bit digit value after the shift
//   corrected - digit minus 3 when digit >= 8, otherwise unchanged
import bcd_to_bin_conv_pkg::*;

module bcd_digit_corr (
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] corrected
);

  assign corrected = (digit >= CORR_THRESH) ? (digit - CORR_SUB) : digit;

endmodule

// File: rtl/bcd_to_bin_conv.sv
// bcd_to_bin_conv: sequential BCD-to-binary converter (reverse double-dabble).
// A rising edge on go (while idle) latches bcd_in; one right shift plus
// per-digit correction runs per clock for BIN_W clocks, then the result is
// published with a one-cycle done pulse. Inputs with a digit > 9 finish
// immediately with err set and a zero result.
// Ports:
//   clk     - system clock, all state on rising edge
//   rst     - synchronous, active-high reset
//   go      - start request level; conversion starts on its rising edge
//   bcd_in  - packed BCD digits, digit 0 in bits [3:0], sampled at start only
//   bin_out - converted value, held until the next completed request
//   busy    - high while shifting
//   done    - one-cycle pulse when bin_out/err are updated
//   err     - last request held an illegal digit
import bcd_to_bin_conv_pkg::*;

module bcd_to_bin_conv #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
  output logic [BIN_W-1:0]          bin_out,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state;
  logic               go_q;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_next;
  logic [BIN_W-1:0]       bin_next;
  logic                   start;
  logic                   bad_digit;

  // Only a fresh edge seen while idle starts work; edges during SHIFT/DONE are dropped.
  assign start = go && !go_q && (state == IDLE);

  // One shift step: the BCD low bit falls into the binary MSB.
  assign shifted  = {bcd_reg, bin_reg} >> 1;
  assign bin_next = shifted[BIN_W-1:0];

  for (genvar d = 0; d < DIGITS; d++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit     (shifted[BIN_W + d*DIGIT_W +: DIGIT_W]),
      .corrected (bcd_next[d*DIGIT_W +: DIGIT_W])
    );
  end

  // NOTE: give every always_comb output a default before any conditional
  // assignment, otherwise a path that skips it infers a latch.
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[d*DIGIT_W +: DIGIT_W] > MAX_DIGIT) bad_digit = 1'b1;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      go_q    <= 1'b0;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      go_q <= go;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            if (bad_digit) begin
              state   <= DONE;
              err     <= 1'b1;
              bin_out <= '0;
              done    <= 1'b1;
            end else begin
              state <= SHIFT;
              err   <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_next;
          cnt     <= cnt + CNT_W'(1);
          // cnt counts completed shifts; this edge performs shift number BIN_W.
          if (cnt == LAST_CNT) begin
            bin_out <= bin_next;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Self-checking bench for bcd_to_bin_conv: directed requests with
// hand-computed results, latency, busy length, done-pulse count and reset.
module tb_bcd_to_bin_conv;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  go;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  int vectors    = 0;
  int miscompares = 0;

  bcd_to_bin_conv #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Drives one request and observes it at each falling edge. Observation i
  // follows rising edge i, where edge 0 samples the start. go stays high for
  // `hold` observations; an optional extra go pulse is given at pulse_at, and
  // bcd_in is replaced by bcd2 right after the start edge.
  task automatic do_request(input logic [15:0] bcd, input logic [15:0] bcd2,
                            input int hold, input int pulse_at, input int window,
                            output int lat, output int busy_cnt, output int done_cnt,
                            output logic [BIN_W-1:0] res, output logic res_err,
                            output logic moved);
    logic [BIN_W-1:0] prev;
    @(negedge clk);
    bcd_in = bcd;
    go     = 1'b1;
    prev   = bin_out;
    lat = -1; busy_cnt = 0; done_cnt = 0; moved = 1'b0;
    res = '0; res_err = 1'b0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && bin_out !== prev) moved = 1'b1;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = i; res = bin_out; res_err = err;
        end
      end
      if (i == 0) bcd_in = bcd2;
      if (i + 1 >= hold) go = 1'b0;
      if (i == pulse_at) go = 1'b1;
      if (i == pulse_at + 1) go = (i + 1 < hold);
    end
    go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; bcd_in = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bin_out, busy, done, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got bin_out=%0d busy=%b done=%b err=%b, want all 0",
               bin_out, busy, done, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_valid(input logic [15:0] bcd, input int exp, input string name);
    int lat, bc, dc; logic [BIN_W-1:0] res; logic re, mv;
    do_request(bcd, bcd, 1, -1, 25, lat, bc, dc, res, re, mv);
    vectors++;
    if (lat !== BIN_W) begin
      miscompares++; $display("FAIL %s_latency: got %0d, want %0d", name, lat, BIN_W);
    end
    vectors++;
    if (res !== BIN_W'(exp) || re !== 1'b0) begin
      miscompares++; $display("FAIL %s_result: got %0d err=%b, want %0d err=0", name, res, re, exp);
    end
    vectors++;
    if (bc !== BIN_W || dc !== 1) begin
      miscompares++; $display("FAIL %s_handshake: got busy=%0d done=%0d, want busy=%0d done=1",
                              name, bc, dc, BIN_W);
    end
    vectors++;
    if (mv !== 1'b0) begin
      miscompares++; $display("FAIL %s_stable: got bin_out moving during busy, want stable", name);
    end
  endtask

  task automatic test_invalid();
    int lat, bc, dc; logic [BIN_W-1:0] res; logic re, mv;
    do_request(16'h12A4, 16'h12A4, 1, -1, 10, lat, bc, dc, res, re, mv);
    vectors++;
    if (lat !== 0 || bc !== 0 || dc !== 1) begin
      miscompares++; $display("FAIL invalid_timing: got lat=%0d busy=%0d done=%0d, want 0 0 1",
                              lat, bc, dc);
    end
    vectors++;
    if (res !== '0 || re !== 1'b1) begin
      miscompares++; $display("FAIL invalid_result: got %0d err=%b, want 0 err=1", res, re);
    end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL invalid_err_held: got err=%b, want 1", err);
    end
    test_valid(16'h0042, 42, "after_invalid");
  endtask

  task automatic test_held_go();
    int lat, bc, dc; logic [BIN_W-1:0] res; logic re, mv;
    do_request(16'h0500, 16'h0500, 40, -1, 45, lat, bc, dc, res, re, mv);
    vectors++;
    if (dc !== 1 || res !== BIN_W'(500) || bc !== BIN_W) begin
      miscompares++; $display("FAIL held_go: got done=%0d bin=%0d busy=%0d, want 1 500 %0d",
                              dc, res, bc, BIN_W);
    end
    do_request(16'h0500, 16'h0500, 1, 5, 25, lat, bc, dc, res, re, mv);
    vectors++;
    if (dc !== 1 || lat !== BIN_W || res !== BIN_W'(500)) begin
      miscompares++; $display("FAIL mid_shift_edge: got done=%0d lat=%0d bin=%0d, want 1 %0d 500",
                              dc, lat, res, BIN_W);
    end
  endtask

  task automatic test_input_change();
    int lat, bc, dc; logic [BIN_W-1:0] res; logic re, mv;
    do_request(16'h0777, 16'h0001, 1, -1, 25, lat, bc, dc, res, re, mv);
    vectors++;
    if (res !== BIN_W'(777) || dc !== 1) begin
      miscompares++; $display("FAIL input_change: got %0d done=%0d, want 777 done=1", res, dc);
    end
  endtask

  task automatic test_reset_mid_shift();
    int dc;
    @(negedge clk);
    bcd_in = 16'h8765; go = 1'b1;
    repeat (8) @(negedge clk);  // observations after edges 0..7
    go = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_busy: got %b, want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bin_out, busy, done, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_shift: got bin_out=%0d busy=%b done=%b err=%b, want all 0",
               bin_out, busy, done, err);
    end
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    vectors++;
    if (dc !== 0) begin
      miscompares++; $display("FAIL no_done_after_reset: got %0d active cycles, want 0", dc);
    end
    test_valid(16'h8765, 8765, "after_reset");
  endtask

  initial begin
    test_reset();
    test_valid(16'h9999, 9999, "max");
    test_valid(16'h1234, 1234, "v1234");
    test_valid(16'h0000, 0, "zero");
    test_invalid();
    test_held_go();
    test_input_change();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
